// File: rtl/irrigation_pkg.sv
// Shared irrigation constants: pump FSM state codes and soil moisture classes.
package irrigation_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ON_MIN   = 3'd1;
  localparam logic [2:0] ON_RUN   = 3'd2;
  localparam logic [2:0] OFF_HOLD = 3'd3;
  localparam logic [2:0] LOCKOUT  = 3'd4;

  localparam logic [1:0] DRY     = 2'b00;
  localparam logic [1:0] OPTIMAL = 2'b01;
  localparam logic [1:0] WET     = 2'b10;

endpackage

// File: rtl/pump_driver_tick_timer.sv
// Saturating tick counter; clear has priority over an increment in the same cycle.
module tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pump_driver.sv
// Safe pump drive: min on/off times, max run with cool-down lockout, enable override.
// Optional PUMP_RUN_COUNT_EN adds a saturating run_count output of pump starts.
module pump_driver
  import irrigation_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MIN_ON_TICKS  = 5,
  parameter int MIN_OFF_TICKS = 10,
  parameter int MAX_ON_TICKS  = 60,
  parameter int LOCKOUT_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        enable,
  input  logic        pump_req,
  input  logic        fault_clr,
  output logic        pump_on,
  output logic [2:0]  state,
  output logic        fault_timeout
`ifdef PUMP_RUN_COUNT_EN
  ,
  output logic [15:0] run_count
`endif
);

  if (MIN_ON_TICKS < 1 || MIN_OFF_TICKS < 1 || MAX_ON_TICKS <= MIN_ON_TICKS ||
      LOCKOUT_TICKS < MIN_OFF_TICKS) begin : g_bad_timing
    $error("pump_driver: inconsistent tick parameters");
  end

  if (MIN_ON_TICKS >= (1 << CNT_W) || MIN_OFF_TICKS >= (1 << CNT_W) ||
      MAX_ON_TICKS >= (1 << CNT_W) || LOCKOUT_TICKS >= (1 << CNT_W)) begin : g_bad_width
    $error("pump_driver: tick parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_OFF_LAST = CNT_W'(MIN_OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] MAX_ON_LAST  = CNT_W'(MAX_ON_TICKS - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_TICKS - 1);

  logic [2:0]       next_state;
  logic             set_fault;
  logic             ph_clear;
  logic             on_clear;
  logic             on_tick;
  logic [CNT_W-1:0] ph_cnt;
  logic [CNT_W-1:0] on_cnt;

  // Counts are judged in the current state; a transition restarts the phase at zero.
  always_comb begin
    next_state = state;
    set_fault  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && pump_req) next_state = ON_MIN;
      end
      ON_MIN: begin
        if (!enable)                           next_state = OFF_HOLD;
        else if (tick && ph_cnt == MIN_ON_LAST) next_state = ON_RUN;
      end
      ON_RUN: begin
        if (!enable) begin
          next_state = OFF_HOLD;
        end else if (tick && on_cnt == MAX_ON_LAST) begin
          next_state = LOCKOUT;
          set_fault  = 1'b1;
        end else if (!pump_req) begin
          next_state = OFF_HOLD;
        end
      end
      OFF_HOLD: begin
        if (tick && ph_cnt == MIN_OFF_LAST) next_state = IDLE;
      end
      LOCKOUT: begin
        if (tick && ph_cnt == LOCKOUT_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign ph_clear = (next_state != state);
  assign on_clear = (next_state == ON_MIN) && (state != ON_MIN);
  assign on_tick  = tick && ((state == ON_MIN) || (state == ON_RUN));

  tick_timer #(.CNT_W(CNT_W)) u_ph_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ph_clear),
    .tick  (tick),
    .count (ph_cnt)
  );

  tick_timer #(.CNT_W(CNT_W)) u_on_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (on_clear),
    .tick  (on_tick),
    .count (on_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pump_on <= 1'b0;
    end else begin
      state   <= next_state;
      pump_on <= (next_state == ON_MIN) || (next_state == ON_RUN);
    end
  end

  // A fault being raised outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_timeout <= 1'b0;
    end else if (set_fault) begin
      fault_timeout <= 1'b1;
    end else if (fault_clr) begin
      fault_timeout <= 1'b0;
    end
  end

`ifdef PUMP_RUN_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count <= '0;
    end else if ((state == IDLE) && (next_state == ON_MIN) && (run_count != 16'hFFFF)) begin
      run_count <= run_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pump_driver.sv
// Directed bench for pump_driver with MIN_ON=2, MIN_OFF=3, MAX_ON=5, LOCKOUT=4, tick every 4 clk.
module tb_pump_driver;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       enable;
  logic       pump_req;
  logic       fault_clr;
  logic       pump_on;
  logic [2:0] state;
  logic       fault_timeout;
`ifdef PUMP_RUN_COUNT_EN
  logic [15:0] run_count;
`endif

  int checks = 0;
  int errors = 0;

  pump_driver #(
    .CNT_W         (8),
    .MIN_ON_TICKS  (2),
    .MIN_OFF_TICKS (3),
    .MAX_ON_TICKS  (5),
    .LOCKOUT_TICKS (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .enable        (enable),
    .pump_req      (pump_req),
    .fault_clr     (fault_clr),
    .pump_on       (pump_on),
    .state         (state),
    .fault_timeout (fault_timeout)
`ifdef PUMP_RUN_COUNT_EN
    ,
    .run_count     (run_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic exp_on, input logic [2:0] exp_st,
                     input logic exp_f);
    check({tag, ".pump_on"}, {7'd0, pump_on}, {7'd0, exp_on});
    check({tag, ".state"}, {5'd0, state}, {5'd0, exp_st});
    check({tag, ".fault"}, {7'd0, fault_timeout}, {7'd0, exp_f});
  endtask

  // One clock with the given tick level; returns 1 ns after the edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Three idle clocks followed by one tick clock.
  task automatic tperiod();
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    tick      = 1'b0;
    enable    = 1'b0;
    pump_req  = 1'b0;
    fault_clr = 1'b0;
    #22;
    chk("reset", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0);
    chk("idle", 1'b0, 3'd0, 1'b0);

    // Single-clock request pulse: 2 ticks on, then 3 ticks off-hold.
    enable   = 1'b1;
    pump_req = 1'b1;
    cyc(1'b0);
    pump_req = 1'b0;
    chk("pulse_start", 1'b1, 3'd1, 1'b0);
    tperiod();
    chk("pulse_tick1", 1'b1, 3'd1, 1'b0);
    tperiod();
    chk("pulse_run", 1'b1, 3'd2, 1'b0);
    cyc(1'b0);
    chk("pulse_stop", 1'b0, 3'd3, 1'b0);
    tperiod();
    tperiod();
    chk("pulse_hold2", 1'b0, 3'd3, 1'b0);
    tperiod();
    chk("pulse_idle", 1'b0, 3'd0, 1'b0);

    // Held request: max run of 5 ticks, fault set despite a coincident clear.
    pump_req = 1'b1;
    cyc(1'b0);
    chk("max_start", 1'b1, 3'd1, 1'b0);
    tperiod();
    tperiod();
    chk("max_run", 1'b1, 3'd2, 1'b0);
    tperiod();
    tperiod();
    chk("max_tick4", 1'b1, 3'd2, 1'b0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    fault_clr = 1'b1;
    cyc(1'b1);
    fault_clr = 1'b0;
    chk("max_lockout", 1'b0, 3'd4, 1'b1);
    tperiod();
    tperiod();
    tperiod();
    chk("lock_tick3", 1'b0, 3'd4, 1'b1);
    tperiod();
    chk("lock_done", 1'b0, 3'd0, 1'b1);
    cyc(1'b0);
    chk("restart", 1'b1, 3'd1, 1'b1);

    // Enable drops one clock after the pump starts.
    enable = 1'b0;
    cyc(1'b0);
    chk("enable_drop", 1'b0, 3'd3, 1'b1);
    pump_req  = 1'b0;
    enable    = 1'b1;
    fault_clr = 1'b1;
    cyc(1'b0);
    fault_clr = 1'b0;
    chk("fault_clr", 1'b0, 3'd3, 1'b0);

    // Short-cycle attempt during off-hold.
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        pump_req = ~pump_req;
        cyc(c == 3);
        if (!(p == 2 && c == 3)) chk("short_cycle", 1'b0, 3'd3, 1'b0);
      end
    end
    chk("short_idle", 1'b0, 3'd0, 1'b0);
    pump_req = 1'b1;
    cyc(1'b0);
    chk("short_restart", 1'b1, 3'd1, 1'b0);
    tperiod();
    tperiod();
    chk("pre_reset_run", 1'b1, 3'd2, 1'b0);

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 3'd0, 1'b0);
    pump_req = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc(1'b0);
    chk("post_reset", 1'b0, 3'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
